// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: PC register feeding a 2-entry {pc, instruction} queue toward decode.
// Optional macro IFU_MISALIGN_TRAP_EN sends misaligned redirects to TRAP_VECTOR with a trap pulse.
module inst_fetch_unit #(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter logic [63:0] TRAP_VECTOR = 64'h100
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] Inst_Address,
    input  logic [31:0] Instruction,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        misalign_trap
);

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      fifo_mem [2];
    logic [63:0] pc;
    logic [1:0]  count;
    logic        head;
    logic        tail;
    logic        pop;
    logic        push;
    logic [63:0] redirect_target;

    assign Inst_Address = pc;
    assign inst_valid   = (count != 2'd0);
    assign pop          = inst_valid && inst_ready;
    // A pop always frees a slot, so a full queue keeps streaming when decode drains it.
    assign push         = !redirect_valid && ((count != 2'd2) || pop);

`ifdef IFU_MISALIGN_TRAP_EN
    logic misaligned;
    logic trap_q;

    assign misaligned      = (redirect_pc[1:0] != 2'b00);
    assign redirect_target = misaligned ? TRAP_VECTOR : redirect_pc;
    assign misalign_trap   = trap_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            trap_q <= 1'b0;
        end else begin
            trap_q <= redirect_valid && misaligned;
        end
    end
`else
    logic unused_trap_inputs;

    assign redirect_target    = {redirect_pc[63:2], 2'b00};
    assign misalign_trap      = 1'b0;
    assign unused_trap_inputs = ^{redirect_pc[1:0], TRAP_VECTOR};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= redirect_target;
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                pc   <= pc + 64'd4;
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            if (push && !pop) begin
                count <= count + 2'd1;
            end else if (pop && !push) begin
                count <= count - 2'd1;
            end
        end
    end

    // NOTE: queue storage is deliberately not reset; count alone defines validity and the outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[tail] <= '{pc: pc, inst: Instruction};
        end
    end

    assign inst_out = inst_valid ? fifo_mem[head].inst : 32'd0;
    assign inst_pc  = inst_valid ? fifo_mem[head].pc   : 64'd0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based reference model compared every cycle,
// plus directed literal checks for reset, stall, redirect, trap and PC wrap behaviour.
module tb_inst_fetch_unit;

    localparam logic [63:0] RESET_PC    = 64'd0;
    localparam logic [63:0] TRAP_VECTOR = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        inst_ready = 1'b0;
    logic [63:0] inst_address;
    logic [31:0] instruction;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        misalign_trap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      model_q[$];
    logic [63:0] model_pc = 64'd0;
    logic        model_trap = 1'b0;
    bit          model_live = 1'b0;

    inst_fetch_unit #(
        .RESET_PC   (RESET_PC),
        .TRAP_VECTOR(TRAP_VECTOR)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Inst_Address  (inst_address),
        .Instruction   (instruction),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_out      (inst_out),
        .inst_pc       (inst_pc),
        .misalign_trap (misalign_trap)
    );

    // Combinational instruction memory: each word is tagged by its address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A00_00C3;
    endfunction

    assign instruction = mem_word(inst_address);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the queue holds exactly what decode should see, oldest first.
    always @(posedge clk) begin
        if (reset) begin
            model_q.delete();
            model_pc   = RESET_PC;
            model_trap = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (redirect_valid) begin
                model_q.delete();
`ifdef IFU_MISALIGN_TRAP_EN
                model_trap = (redirect_pc[1:0] != 2'b00);
                model_pc   = model_trap ? TRAP_VECTOR : redirect_pc;
`else
                model_trap = 1'b0;
                model_pc   = redirect_pc & ~64'd3;
`endif
            end else begin
                model_trap = 1'b0;
                if (model_q.size() > 0 && inst_ready) void'(model_q.pop_front());
                if (model_q.size() < 2) begin
                    model_q.push_back('{model_pc, mem_word(model_pc)});
                    model_pc = model_pc + 64'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_live) begin
            logic [31:0] exp_inst;
            logic [63:0] exp_pc;
            exp_inst = 32'd0;
            exp_pc   = 64'd0;
            if (model_q.size() > 0) begin
                exp_inst = model_q[0].inst;
                exp_pc   = model_q[0].pc;
            end
            check("inst_valid", 64'(inst_valid), 64'(model_q.size() != 0));
            check("inst_address", inst_address, model_pc);
            check("inst_out", 64'(inst_out), 64'(exp_inst));
            check("inst_pc", inst_pc, exp_pc);
            check("misalign_trap", 64'(misalign_trap), 64'(model_trap));
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(inst_valid), 64'd0);
        check("rst_addr", inst_address, 64'd0);
        check("rst_inst_out", 64'(inst_out), 64'd0);
        check("rst_inst_pc", inst_pc, 64'd0);
        check("rst_trap", 64'(misalign_trap), 64'd0);

        // Streaming with decode always ready
        reset      = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("stream_addr1", inst_address, 64'd4);
        check("stream_valid1", 64'(inst_valid), 64'd1);
        check("stream_pc1", inst_pc, 64'd0);
        check("stream_inst1", 64'(inst_out), 64'(mem_word(64'd0)));
        tick();
        check("stream_addr2", inst_address, 64'd8);
        check("stream_pc2", inst_pc, 64'd4);
        tick();
        check("stream_pc3", inst_pc, 64'd8);

        // Stall: queue saturates at two entries, PC holds
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        inst_ready = 1'b0;
        repeat (5) tick();
        check("stall_addr", inst_address, 64'd8);
        check("stall_pc", inst_pc, 64'd0);
        check("model_full", 64'(model_q.size()), 64'd2);
        inst_ready = 1'b1;
        tick();
        check("drain_pc1", inst_pc, 64'd4);
        check("drain_addr1", inst_address, 64'd12);
        tick();
        check("drain_pc2", inst_pc, 64'd8);
        check("drain_addr2", inst_address, 64'd16);
        tick();
        check("full_stream_addr", inst_address, 64'd20);
        check("model_still_full", 64'(model_q.size()), 64'd2);

        // Redirect while full
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        tick();
        check("redir_valid", 64'(inst_valid), 64'd0);
        check("redir_addr", inst_address, 64'h200);
        redirect_valid = 1'b0;
        tick();
        check("redir_head_valid", 64'(inst_valid), 64'd1);
        check("redir_head_pc", inst_pc, 64'h200);
        check("redir_next_addr", inst_address, 64'h204);

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc    = 64'h202;
        tick();
`ifdef IFU_MISALIGN_TRAP_EN
        check("mis_trap", 64'(misalign_trap), 64'd1);
        check("mis_addr", inst_address, 64'h100);
`else
        check("mis_trap", 64'(misalign_trap), 64'd0);
        check("mis_addr", inst_address, 64'h200);
`endif
        redirect_valid = 1'b0;
        tick();
        check("mis_trap_end", 64'(misalign_trap), 64'd0);

        // PC wrap at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        check("wrap_addr0", inst_address, 64'hFFFF_FFFF_FFFF_FFFC);
        redirect_valid = 1'b0;
        tick();
        check("wrap_addr1", inst_address, 64'd0);
        check("wrap_head_pc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);

        // Reset beats a redirect with the queue full
        inst_ready = 1'b0;
        repeat (3) tick();
        reset          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h302;
        tick();
        check("rst_ovr_valid", 64'(inst_valid), 64'd0);
        check("rst_ovr_addr", inst_address, RESET_PC);
        check("rst_ovr_trap", 64'(misalign_trap), 64'd0);
        reset          = 1'b0;
        redirect_valid = 1'b0;

        // Randomized traffic, checked every cycle against the model
        for (int i = 0; i < 3000; i++) begin
            reset          = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) redirect_pc[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
            inst_ready     = ($urandom_range(0, 3) != 0);
            tick();
        end

        reset          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
